cpu_output_pio: RTL and testbench



---
 rtl/cpu_output_pio_pkg.sv | 10 +
 rtl/cpu_output_pio_pulse_timer.sv | 36 +++
 rtl/cpu_output_pio.sv | 69 ++++++
 tb/tb_cpu_output_pio.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cpu_output_pio_pkg.sv
// cpu_output_pio_pkg: register offsets and pulse FSM state shared by the output PIO.
package cpu_output_pio_pkg;
    localparam logic [2:0] OFF_DATA   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_PULSE  = 3'd2;
    localparam logic [2:0] OFF_PLEN   = 3'd3;
    localparam logic [2:0] OFF_SET    = 3'd4;
    localparam logic [2:0] OFF_CLR    = 3'd5;
    typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/cpu_output_pio_pulse_timer.sv
// cpu_output_pio_pulse_timer: one-shot length counter; expire strobes on the last pulse cycle.
module cpu_output_pio_pulse_timer
    import cpu_output_pio_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             cancel,
    input  logic [CNT_W-1:0] plen,
    output logic             busy,
    output logic             expire
);
    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign busy   = state == ACTIVE;
    assign expire = busy && cnt == CNT_W'(1) && !load && !cancel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (cancel) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (load) begin
            state <= ACTIVE;
            cnt   <= (plen == '0) ? CNT_W'(1) : plen;
        end else if (busy) begin
            state <= (cnt == CNT_W'(1)) ? IDLE : ACTIVE;
            cnt   <= cnt - CNT_W'(1);
        end
    end
endmodule

// File: rtl/cpu_output_pio.sv
// cpu_output_pio: Avalon-MM output port with atomic set/clear and a hardware one-shot pulse.
module cpu_output_pio
    import cpu_output_pio_pkg::*;
#(
    parameter int          WIDTH         = 8,
    parameter logic [31:0] RESET_VALUE   = 32'd0,
    parameter int          CNT_W         = 16,
    parameter logic [31:0] PULSE_DEFAULT = 32'd16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic [WIDTH-1:0] out_reg, pulse_mask, wd, out_w, mask_w;
    logic [CNT_W-1:0] plen;
    logic [31:0]      rd_n;
    logic             wr, wr_data, wr_pulse, wr_set, wr_clr, load, busy, expire;
    logic             unused_wd;

    assign unused_wd = ^writedata;
    assign wd        = writedata[WIDTH-1:0];
    assign wr        = chipselect && !write_n;
    assign wr_data   = wr && address == OFF_DATA;
    assign wr_pulse  = wr && address == OFF_PULSE;
    assign wr_set    = wr && address == OFF_SET;
    assign wr_clr    = wr && address == OFF_CLR;
    // A zero PULSE write only matters as a restart of a running pulse
    assign load      = wr_pulse && (wd != '0 || busy);
    assign out_port  = out_reg;

    cpu_output_pio_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .cancel  (wr_data),
        .plen    (plen),
        .busy    (busy),
        .expire  (expire)
    );

    // Write effect first; expiry then drops whatever the updated mask still owns
    always_comb begin
        out_w  = wr_data ? wd : (load || wr_set) ? (out_reg | wd) : wr_clr ? (out_reg & ~wd) : out_reg;
        mask_w = wr_data ? '0 : load ? (pulse_mask | wd) : (wr_set || wr_clr) ? (pulse_mask & ~wd) : pulse_mask;
        rd_n   = address == OFF_DATA   ? 32'(out_reg) :
                 address == OFF_STATUS ? {31'b0, busy} :
                 address == OFF_PULSE  ? 32'(pulse_mask) :
                 address == OFF_PLEN   ? 32'(plen) : 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_reg    <= RESET_VALUE[WIDTH-1:0];
            pulse_mask <= '0;
            plen       <= PULSE_DEFAULT[CNT_W-1:0];
            readdata   <= '0;
        end else begin
            out_reg    <= expire ? (out_w & ~mask_w) : out_w;
            pulse_mask <= expire ? '0 : mask_w;
            plen       <= (wr && address == OFF_PLEN) ? writedata[CNT_W-1:0] : plen;
            readdata   <= rd_n;
        end
    end
endmodule

// File: tb/tb_cpu_output_pio.sv
// tb_cpu_output_pio: directed per-cycle vector table plus an asynchronous mid-pulse reset sequence.
module tb_cpu_output_pio;
    logic        clk = 0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata, readdata;
    logic [7:0]  out_port;
    int          checks = 0, errors = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  a;
        logic [31:0] d;
        logic [7:0]  port;
        logic [31:0] rd;
    } vec_t;
    vec_t vq[$];

    cpu_output_pio dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [2:0] a, input logic [31:0] d,
                       input logic [7:0] port, input logic [31:0] rd);
        vq.push_back('{wr, a, d, port, rd});
    endtask

    task automatic cyc(input logic cs, input logic wr, input logic [2:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = !wr;
        address    = a;
        writedata  = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0;
        // wr, addr, data, expected out_port, expected readdata (both after the edge)
        add(0, 0, 0,    8'h00, 32'h00);
        add(0, 1, 0,    8'h00, 32'h00);
        add(0, 3, 0,    8'h00, 32'h10);
        add(1, 0, 'hA5, 8'hA5, 32'h00);
        add(0, 0, 0,    8'hA5, 32'hA5);
        add(1, 0, 'h0F, 8'h0F, 32'hA5);
        add(1, 4, 'h30, 8'h3F, 32'h00);
        add(1, 5, 'h03, 8'h3C, 32'h00);
        add(0, 0, 0,    8'h3C, 32'h3C);
        add(1, 3, 4,    8'h3C, 32'h10);
        add(0, 3, 0,    8'h3C, 32'h04);
        add(1, 2, 'h80, 8'hBC, 32'h00);
        add(0, 1, 0,    8'hBC, 32'h01);
        add(0, 2, 0,    8'hBC, 32'h80);
        add(0, 1, 0,    8'hBC, 32'h01);
        add(0, 1, 0,    8'h3C, 32'h01);
        add(0, 1, 0,    8'h3C, 32'h00);
        add(0, 2, 0,    8'h3C, 32'h00);
        add(1, 2, 'h01, 8'h3D, 32'h00);
        add(0, 2, 0,    8'h3D, 32'h01);
        add(1, 2, 'h02, 8'h3F, 32'h01);
        add(0, 2, 0,    8'h3F, 32'h03);
        add(0, 0, 0,    8'h3F, 32'h3F);
        add(0, 1, 0,    8'h3F, 32'h01);
        add(0, 1, 0,    8'h3C, 32'h01);
        add(0, 2, 0,    8'h3C, 32'h00);
        add(1, 2, 'h81, 8'hBD, 32'h00);
        add(0, 0, 0,    8'hBD, 32'hBD);
        add(0, 0, 0,    8'hBD, 32'hBD);
        add(0, 0, 0,    8'hBD, 32'hBD);
        add(1, 4, 'h80, 8'hBC, 32'h00);
        add(0, 1, 0,    8'hBC, 32'h00);
        add(0, 2, 0,    8'hBC, 32'h00);
        add(1, 2, 'h01, 8'hBD, 32'h00);
        add(0, 1, 0,    8'hBD, 32'h01);
        add(1, 0, 'h00, 8'h00, 32'hBD);
        add(0, 1, 0,    8'h00, 32'h00);
        add(0, 0, 0,    8'h00, 32'h00);
        add(0, 0, 0,    8'h00, 32'h00);
        add(1, 3, 0,    8'h00, 32'h04);
        add(0, 3, 0,    8'h00, 32'h00);
        add(1, 2, 'h04, 8'h04, 32'h00);
        add(0, 1, 0,    8'h00, 32'h01);
        add(0, 1, 0,    8'h00, 32'h00);
        add(1, 2, 'h00, 8'h00, 32'h00);
        add(0, 1, 0,    8'h00, 32'h00);
        add(1, 1, 'hFF, 8'h00, 32'h00);
        add(0, 6, 0,    8'h00, 32'h00);

        repeat (2) @(negedge clk);
        chk("reset_port", 32'(out_port), 32'h0);
        chk("reset_rd", readdata, 32'h0);
        reset_n = 1;
        foreach (vq[i]) begin
            cyc(1, vq[i].wr, vq[i].a, vq[i].d);
            chk($sformatf("v%0d_port", i), 32'(out_port), 32'(vq[i].port));
            chk($sformatf("v%0d_rd", i), readdata, vq[i].rd);
        end

        // Asynchronous reset in the middle of a running pulse
        cyc(1, 1, 3, 4);
        cyc(1, 1, 2, 'h10);
        cyc(0, 0, 1, 0);
        chk("mid_pulse_port", 32'(out_port), 32'h10);
        chk("mid_pulse_busy", readdata, 32'h1);
        #2 reset_n = 0;
        #1;
        chk("async_reset_port", 32'(out_port), 32'h0);
        chk("async_reset_rd", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1;
        cyc(0, 0, 1, 0);
        chk("post_reset_busy", readdata, 32'h0);
        cyc(0, 0, 3, 0);
        chk("post_reset_plen", readdata, 32'h10);
        repeat (5) cyc(0, 0, 0, 0);
        chk("post_reset_port", 32'(out_port), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
